instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the main control decoder: turns a structured instruction command into a 32-bit RV32I machine word for the supported subset (lw, sw, R-type, beq, I-type ALU, jal, plus nop).
- Used by the instruction-memory loader and the verification stimulus path to fill instruction memory.
- Buffers encoded words in a small FIFO, with valid/ready handshakes on both sides.
- Tags each word with its instruction-memory byte address and flags commands that cannot be encoded.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
ADDR_W, 32, width of the instruction-memory byte address
BASE_ADDR, 0, byte address of the first emitted word after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  command valid
in_ready  out  1  command accepted when in_valid&in_ready
in_kind  in  3  000 lw, 001 sw, 010 R, 011 beq, 100 I-ALU, 101 jal, 110 nop, 111 illegal
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_funct3  in  3  funct3 (R, I-ALU only)
in_funct7b5  in  1  instr[30] (R; I-ALU with funct3=101)
in_imm  in  21  signed immediate (byte offset for beq/jal)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_instr  out  32  encoded word at FIFO head
out_addr  out  ADDR_W  byte address of head word
err  out  1  one-cycle pulse: a command was rejected
err_count  out  8  saturating count of rejected commands

Behaviour:
- Reset (reset=0, async): FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_count=0. in_ready=0 while reset is asserted; in_ready=1 from the first clk edge after release.
- in_ready = !full. No bypass: a pop in the same cycle does not make a full FIFO accept.
- Encoding is combinational on accepted inputs; the word is pushed at the accept edge. out_valid rises the next cycle, so latency is 1 cycle when the FIFO is empty.
- Opcodes and field rules:
  - lw: opcode 0000011, funct3 forced 010.
  - sw: opcode 0100011, funct3 forced 010.
  - R-type: opcode 0110011, funct7 = {0, funct7b5, 00000}.
  - beq: opcode 1100011, funct3 forced 000.
  - I-ALU: opcode 0010011.
  - jal: opcode 1101111.
  - nop: emits 0x00000013.
- Immediates use standard I/S/B/J bit scattering.
- Unused fields are ignored. Examples: rs2 for lw/I/jal, rd for sw/beq, all register fields for nop.
- I-ALU with funct3=001 or 101 (shift): imm[11:5] = {0, funct7b5, 00000}, imm[4:0] = in_imm[4:0]. Reject if in_imm is outside 0..31.
- Rejection rules:
  - lw/sw/I-ALU (non-shift): in_imm outside -2048..2047.
  - beq: in_imm outside -4096..4094, or in_imm[0]=1.
  - jal: in_imm[0]=1. The 21-bit range is implicit.
  - in_kind=111.
- A rejected command is still consumed (handshake completes) but is not pushed. err pulses 1 cycle after the accept edge. err_count increments and saturates at 255.
- Output handshake: on out_valid&out_ready, pop the head. out_addr advances by 4 (mod 2^ADDR_W) and labels the next head. out_instr/out_addr hold stable while out_valid&!out_ready.
- Push and pop in the same cycle when not full: both occur; occupancy is unchanged.
- Empty FIFO: out_instr holds the last popped value (0 after reset); it is don't-care while out_valid=0.
- Pointers wrap modulo FIFO_DEPTH; a separate count or extra pointer bit distinguishes full from empty.
- Reset mid-stream: FIFO contents are discarded, out_addr returns to BASE_ADDR, and err_count is cleared.

Test Plan:
- Each encode below is checked with out_ready=1:
  - addi x5,x0,10 (kind 100, f3 000, imm 10) -> 0x00A00293.
  - lw x6,8(x5) -> 0x0082A303.
  - sw x6,4(x5) -> 0x0062A223.
  - sub x7,x5,x6 (f7b5=1) -> 0x406283B3.
  - beq x5,x6,8 -> 0x00628463.
  - jal x1,8 -> 0x008000EF.
  - nop -> 0x00000013.
  - out_addr for these runs 0,4,8,... and each word appears 1 cycle after accept.
- Rejection: beq with imm=5, then lw with imm=2048, then kind 111. Required: three err pulses, err_count=3, no words emitted, out_addr unchanged. A following addi encodes normally.
- Backpressure with out_ready=0 and FIFO_DEPTH=4: in_ready drops after 4 accepts and a 5th command stalls. Raising out_ready drains the words in order with addresses 0,4,8,12, after which the 5th word gets address 16.
- Simultaneous push/pop at occupancy 2 with continuous streaming of 100 random valid commands and random out_ready: ordering is preserved, with no loss or duplication, checked against a reference encoder.
- Reset asserted with 3 entries queued and err_count=2: outputs drop to reset values immediately (asynchronously). After release, the first word gets out_addr=BASE_ADDR.
- err_count saturation: 300 illegal commands -> err_count=255 and no wrap.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Command/word handshake bundle for instr_encoder.
//   in_*       : structured instruction command (valid/ready)
//   out_*      : encoded 32-bit word plus its instruction-memory byte address (valid/ready)
//   err        : one-cycle pulse when a command is rejected
//   err_count  : saturating count of rejected commands
// master = command producer / word consumer, slave = the encoder.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_kind;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_funct3;
   logic              in_funct7b5;
   logic [20:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              err;
   logic [7:0]        err_count;

   modport master (
      output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
      output out_ready,
      input  in_ready, out_valid, out_instr, out_addr, err, err_count
   );

   modport slave (
      input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
      input  out_ready,
      output in_ready, out_valid, out_instr, out_addr, err, err_count
   );
endinterface

// File: rtl/instr_encoder.sv
// RV32I subset encoder (lw, sw, R-type, beq, I-ALU, jal, nop) with an output FIFO.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : instr_encoder_if.slave (command in, tagged word out, error reporting)
// Accepted commands are encoded combinationally and pushed at the accept edge; commands
// that cannot be encoded are consumed, counted and flagged instead of pushed.
module instr_encoder #(
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input logic              clk,
   input logic              reset,
   instr_encoder_if.slave   bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [31:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       last_q;
   logic              ready_q;
   logic              err_q;
   logic [7:0]        err_cnt_q;

   logic full, empty, accept, push, pop;
   logic [31:0] word;
   logic legal;

   logic [20:0]        imm;
   logic signed [20:0] imm_s;
   logic fits_i, fits_b, fits_sh, is_shift;

   assign imm      = bus.in_imm;
   assign imm_s    = $signed(bus.in_imm);
   assign fits_i   = (imm_s >= -21'sd2048) && (imm_s <= 21'sd2047);
   assign fits_b   = (imm_s >= -21'sd4096) && (imm_s <= 21'sd4094) && !imm[0];
   assign fits_sh  = (imm_s >= 21'sd0) && (imm_s <= 21'sd31);
   assign is_shift = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);

   always_comb begin
      word  = 32'h0;
      legal = 1'b1;
      unique case (bus.in_kind)
         3'b000: begin
            word  = {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
            legal = fits_i;
         end
         3'b001: begin
            word  = {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], 7'b0100011};
            legal = fits_i;
         end
         3'b010: begin
            word = {1'b0, bus.in_funct7b5, 5'b00000, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_rd, 7'b0110011};
         end
         3'b011: begin
            word  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000, imm[4:1], imm[11],
                     7'b1100011};
            legal = fits_b;
         end
         3'b100: begin
            if (is_shift) begin
               // Shift immediates carry funct7 in imm[11:5] and a 5-bit shamt.
               word  = {1'b0, bus.in_funct7b5, 5'b00000, imm[4:0], bus.in_rs1, bus.in_funct3,
                        bus.in_rd, 7'b0010011};
               legal = fits_sh;
            end else begin
               word  = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011};
               legal = fits_i;
            end
         end
         3'b101: begin
            word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
            legal = !imm[0];
         end
         3'b110: word = 32'h0000_0013;
         3'b111: legal = 1'b0;
      endcase
   end

   assign full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign empty  = (count_q == '0);
   assign accept = bus.in_valid && bus.in_ready;
   assign push   = accept && legal;
   assign pop    = bus.out_valid && bus.out_ready;

   // No bypass: a pop in the same cycle never opens a full FIFO.
   assign bus.in_ready  = ready_q && !full;
   assign bus.out_valid = !empty;
   assign bus.out_instr = empty ? last_q : mem[rd_ptr_q];
   assign bus.out_addr  = addr_q;
   assign bus.err       = err_q;
   assign bus.err_count = err_cnt_q;

   // Storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         addr_q    <= BASE_ADDR;
         last_q    <= 32'h0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= 8'h00;
      end else begin
         ready_q <= 1'b1;
         err_q   <= accept && !legal;
         if (accept && !legal && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            last_q   <= mem[rd_ptr_q];
            addr_q   <= addr_q + ADDR_W'(4);
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end
endmodule
